// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor / next-PC controller.
package bp_pkg;

    // next-PC mux select
    localparam logic [1:0] SEL_SEQ   = 2'd0;
    localparam logic [1:0] SEL_JAL   = 2'd1;
    localparam logic [1:0] SEL_REDIR = 2'd2;

    // 2-bit saturating counter values
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // flush sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FL1  = 2'd1,
        ST_FL2  = 2'd2
    } fl_state_t;

    // saturating counter step toward the resolved outcome
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == CTR_ST) ? c : c + 2'd1;
        else
            return (c == CTR_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: two async read ports (fetch lookup and
// resolve-side hit check) and one sync write port. Reads see the
// pre-write contents in the write cycle.
module btb_array
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    // fetch lookup port
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_target,
    output logic [1:0]       rd_ctr,
    // resolve-side read port
    input  logic [IDX_W-1:0] upd_idx,
    output logic             upd_valid,
    output logic [TAG_W-1:0] upd_tag,
    output logic [31:0]      upd_target,
    output logic [1:0]       upd_ctr,
    // write port (a write always marks the entry valid)
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target,
    input  logic [1:0]       wr_ctr
);

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][1:0]       ctr_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][31:0]      target_q;

    assign rd_valid   = valid_q[rd_idx];
    assign rd_tag     = tag_q[rd_idx];
    assign rd_target  = target_q[rd_idx];
    assign rd_ctr     = ctr_q[rd_idx];

    assign upd_valid  = valid_q[upd_idx];
    assign upd_tag    = tag_q[upd_idx];
    assign upd_target = target_q[upd_idx];
    assign upd_ctr    = ctr_q[upd_idx];

    // valid and counter state, cleared to weakly-not-taken on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= wr_ctr;
        end
    end

    // tag and target payload; meaningless while valid=0 so never reset
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch prediction and next-PC control: BTB lookup at IF, resolve and
// update at EX/MEM, mispredict redirect select and a two-cycle flush.
module branch_pred_ctrl
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_is_jal,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [1:0]  sel,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] mispredict_cnt
);

    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             rd_valid, upd_valid;
    logic [TAG_W-1:0] rd_tag, upd_tag;
    logic [31:0]      rd_target, upd_target;
    logic [1:0]       rd_ctr, upd_ctr;
    logic             we;
    logic [31:0]      wr_target;
    logic [1:0]       wr_ctr;
    logic             if_hit, upd_hit;
    logic             resolve, eff_taken, mispredict;
    fl_state_t        state;

    // byte-offset bits never address the BTB
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    btb_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (if_idx),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_ctr     (rd_ctr),
        .upd_idx    (ex_idx),
        .upd_valid  (upd_valid),
        .upd_tag    (upd_tag),
        .upd_target (upd_target),
        .upd_ctr    (upd_ctr),
        .we         (we),
        .wr_idx     (ex_idx),
        .wr_tag     (ex_tag),
        .wr_target  (wr_target),
        .wr_ctr     (wr_ctr)
    );

    // fetch-side prediction
    assign if_hit      = rd_valid && (rd_tag == if_tag);
    assign pred_taken  = if_hit && rd_ctr[1];
    assign pred_target = if_hit ? rd_target : if_pc + 32'd4;

    // resolve and mispredict; JAL is always taken and wins over a branch flag
    assign resolve    = ex_valid && (ex_is_br || ex_is_jal) && !stall;
    assign eff_taken  = ex_is_jal || ex_taken;
    assign mispredict = (ex_pred_taken != eff_taken) ||
                        (eff_taken && (ex_pred_target != ex_target));
    assign upd_hit    = upd_valid && (upd_tag == ex_tag);

    assign redirect_pc = eff_taken ? ex_target : ex_pc + 32'd4;

    // BTB write decision: JAL (over)writes strong-taken, branch hit steps the
    // counter keeping its target, taken branch miss allocates weak-taken
    always_comb begin
        we        = 1'b0;
        wr_target = ex_target;
        wr_ctr    = CTR_WT;
        if (resolve) begin
            if (ex_is_jal) begin
                we     = 1'b1;
                wr_ctr = CTR_ST;
            end else if (upd_hit) begin
                we        = 1'b1;
                wr_target = upd_target;
                wr_ctr    = ctr_next(upd_ctr, ex_taken);
            end else if (ex_taken) begin
                we = 1'b1;
            end
        end
    end

    // next-PC select; the JAL leg is unreachable but keeps the mux fully coded
    always_comb begin
        sel = SEL_SEQ;
        if (resolve && mispredict)
            sel = SEL_REDIR;
        else if (resolve && ex_is_jal && !ex_pred_taken)
            sel = SEL_JAL;
    end

    // flush sequencer: a mispredict (re)starts FL1, stall freezes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            flush <= 1'b0;
        end else if (resolve && mispredict) begin
            state <= ST_FL1;
            flush <= 1'b1;
        end else if (!stall) begin
            case (state)
                ST_FL1:  begin state <= ST_FL2;  flush <= 1'b1; end
                ST_FL2:  begin state <= ST_IDLE; flush <= 1'b0; end
                default: begin state <= ST_IDLE; flush <= 1'b0; end
            endcase
        end
    end

    // saturating mispredict counter
    always_ff @(posedge clk) begin
        if (rst)
            mispredict_cnt <= 32'd0;
        else if (resolve && mispredict && (mispredict_cnt != 32'hFFFF_FFFF))
            mispredict_cnt <= mispredict_cnt + 32'd1;
    end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench for branch_pred_ctrl: expectations are queued as each
// cycle's stimulus is driven and drained against the DUT at the falling edge.
module tb_branch_pred_ctrl;

    localparam int F_PT = 0, F_PTGT = 1, F_SEL = 2, F_RPC = 3, F_FL = 4, F_CNT = 5;

    logic        clk, rst, stall;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_br, ex_is_jal, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic [1:0]  sel;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] mispredict_cnt;

    typedef struct {
        int          fld;
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    branch_pred_ctrl #(.ENTRIES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_is_jal      (ex_is_jal),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .sel            (sel),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int fld);
        case (fld)
            F_PT:    return {31'd0, pred_taken};
            F_PTGT:  return pred_target;
            F_SEL:   return {30'd0, sel};
            F_RPC:   return redirect_pc;
            F_FL:    return {31'd0, flush};
            default: return mispredict_cnt;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic want(input int fld, input string tag, input logic [31:0] v);
        exp_t e;
        e.fld = fld;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    // compare this cycle's queued expectations, then step past the edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.fld), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic br, input logic jal, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_br       = br;
        ex_is_jal      = jal;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
        ex_is_br = 1'b0;
        ex_is_jal = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; if_pc = 32'h0;
        idle_ex();
        ex_pc = 0; ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        if_pc = 32'h100;
        want(F_PT, "rst_pt", 0); want(F_PTGT, "rst_ptgt", 32'h104);
        want(F_FL, "rst_flush", 0); want(F_CNT, "rst_cnt", 0); want(F_SEL, "rst_sel", 0);
        tick();

        // first taken branch 0x200 -> 0x180, predicted not taken
        if_pc = 32'h200;
        set_ex(1, 0, 32'h200, 1, 32'h180, 0, 32'h204);
        want(F_PT, "rbw_pt", 0); want(F_SEL, "br_sel", 2);
        want(F_RPC, "br_rpc", 32'h180); want(F_FL, "br_flush0", 0);
        tick();
        idle_ex();
        want(F_FL, "br_fl1", 1); want(F_PT, "alloc_pt", 1);
        want(F_PTGT, "alloc_ptgt", 32'h180); want(F_CNT, "br_cnt", 1);
        tick();
        want(F_FL, "br_fl2", 1);
        tick();
        want(F_FL, "br_fl_done", 0);
        tick();

        // three not-taken resolves: ctr 10 -> 01 -> 00 -> 00
        for (int i = 0; i < 3; i++) begin
            if_pc = 32'h200;
            set_ex(1, 0, 32'h200, 0, 32'h180, i == 0, (i == 0) ? 32'h180 : 32'h204);
            want(F_PT, $sformatf("nt%0d_pt", i), (i == 0) ? 32'd1 : 32'd0);
            want(F_SEL, $sformatf("nt%0d_sel", i), (i == 0) ? 32'd2 : 32'd0);
            want(F_RPC, $sformatf("nt%0d_rpc", i), 32'h204);
            tick();
        end
        idle_ex();
        want(F_CNT, "nt_cnt", 2); want(F_PT, "nt_pt", 0); want(F_PTGT, "nt_hit_tgt", 32'h180);
        tick();
        // one taken step from 00 lands on 01: still predicted not taken
        set_ex(1, 0, 32'h200, 1, 32'h180, 0, 32'h204);
        want(F_SEL, "sat_sel", 2);
        tick();
        idle_ex();
        want(F_PT, "sat_pt", 0); want(F_CNT, "sat_cnt", 3);
        tick(); tick(); tick();

        // aliasing: 0x240 shares index 0 with 0x200 and evicts it
        set_ex(1, 0, 32'h240, 1, 32'h500, 0, 32'h244);
        want(F_SEL, "alias_sel", 2);
        tick();
        idle_ex();
        if_pc = 32'h200;
        want(F_PT, "alias_old_pt", 0); want(F_PTGT, "alias_old_ptgt", 32'h204);
        want(F_CNT, "alias_cnt", 4);
        tick();
        if_pc = 32'h240;
        want(F_PT, "alias_new_pt", 1); want(F_PTGT, "alias_new_ptgt", 32'h500);
        tick(); tick(); tick();

        // JAL 0x300 -> 0x400: first encounter mispredicts, second does not
        if_pc = 32'h300;
        set_ex(0, 1, 32'h300, 1, 32'h400, 0, 32'h304);
        want(F_PT, "jal1_pt", 0); want(F_SEL, "jal1_sel", 2); want(F_RPC, "jal1_rpc", 32'h400);
        tick();
        idle_ex();
        want(F_PT, "jal_pt", 1); want(F_PTGT, "jal_ptgt", 32'h400); want(F_CNT, "jal1_cnt", 5);
        tick(); tick(); tick();
        set_ex(0, 1, 32'h300, 1, 32'h400, 1, 32'h400);
        want(F_SEL, "jal2_sel", 0); want(F_RPC, "jal2_rpc", 32'h400);
        tick();
        idle_ex();
        want(F_CNT, "jal2_cnt", 5); want(F_FL, "jal2_flush", 0);
        tick();

        // mispredict then stall for 3 cycles in FL1
        set_ex(1, 0, 32'h600, 1, 32'h700, 0, 32'h604);
        want(F_SEL, "stl_sel", 2);
        tick();
        stall = 1'b1;
        set_ex(1, 0, 32'h800, 1, 32'h900, 0, 32'h804);
        for (int i = 0; i < 3; i++) begin
            want(F_FL, $sformatf("stl%0d_flush", i), 1);
            want(F_SEL, $sformatf("stl%0d_sel", i), 0);
            want(F_CNT, $sformatf("stl%0d_cnt", i), 6);
            tick();
        end
        stall = 1'b0;
        idle_ex();
        want(F_FL, "rel_fl1", 1); tick();
        want(F_FL, "rel_fl2", 1); tick();
        want(F_FL, "rel_idle", 0); tick();

        // back-to-back mispredicts restart FL1 and both count
        set_ex(1, 0, 32'h800, 1, 32'h900, 0, 32'h804);
        tick();
        set_ex(1, 0, 32'h900, 1, 32'hA00, 0, 32'h904);
        want(F_FL, "b2b_fl_a", 1); want(F_SEL, "b2b_sel", 2);
        tick();
        idle_ex();
        want(F_FL, "b2b_fl_b", 1); want(F_CNT, "b2b_cnt", 8); tick();
        want(F_FL, "b2b_fl_c", 1); tick();
        want(F_FL, "b2b_idle", 0); tick();

        // reset in the middle of a flush
        set_ex(0, 1, 32'h300, 1, 32'h400, 0, 32'h304);
        tick();
        idle_ex();
        want(F_FL, "mid_flush", 1); want(F_CNT, "mid_cnt", 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_pc = 32'h240;
        want(F_FL, "rr_flush", 0); want(F_CNT, "rr_cnt", 0);
        want(F_PT, "rr_pt", 0); want(F_PTGT, "rr_ptgt", 32'h244);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/branch_pred_ctrl.md
# branch_pred_ctrl

Branch prediction and next-PC controller for the RV32 pipeline. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and looks it up at IF to produce a predicted target. At EX/MEM it resolves branch/JAL outcomes, updates the BTB, and detects mispredictions. It generates the select, redirect address and pipeline flush sequence that drive the jump/branch next-PC mux.

## Interface
Parameters:
- ENTRIES, 16, BTB entry count; power of two, 4..256
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes flush FSM and suppresses BTB updates
- if_pc  in  32  fetch PC
- pred_taken  out  1  BTB hit and counter[1]==1
- pred_target  out  32  BTB target on hit, else if_pc+4
- ex_valid  in  1  resolving instruction valid in EX/MEM
- ex_is_br  in  1  conditional branch
- ex_is_jal  in  1  JAL
- ex_pc  in  32  PC of resolving instruction
- ex_taken  in  1  actual outcome (forced 1 for JAL)
- ex_target  in  32  actual target
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_pred_target  in  32  predicted target carried down the pipe
- sel  out  2  next-PC select: 0 = predicted/sequential, 1 = JAL target, 2 = redirect
- redirect_pc  out  32  ex_taken ? ex_target : ex_pc+4
- flush  out  1  kill IF/ID and ID/EX contents
- mispredict_cnt  out  32  saturating mispredict count

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Entry fields: valid, tag, target[31:0], ctr[1:0].
- Lookup is combinational from if_pc. Hit = valid && tag match.
- Resolve fires when ex_valid && (ex_is_br || ex_is_jal) && !stall.
- Mispredict is defined as ex_pred_taken != ex_taken, or ex_taken && ex_pred_target != ex_target.
- Branch update:
  - On hit: ctr increments when taken and decrements when not taken, saturating at 00 and 11.
  - On miss and taken: allocate the entry with tag, target and ctr=10.
  - On miss and not taken: no change.
- JAL update: allocate or overwrite with ctr=11 and target=ex_target.
- sel:
  - 2 when resolve && mispredict.
  - 1 when resolve && ex_is_jal && !mispredict && ex_pred_taken==0. This case cannot occur by definition and is kept for mux completeness only.
  - 0 otherwise.
- Flush FSM:
  - States: IDLE, FL1, FL2.
  - Resolve && mispredict moves any state to FL1.
  - FL1 → FL2 → IDLE.
  - flush=1 in FL1 and FL2.
  - stall holds the current state.
- mispredict_cnt increments once per mispredicting resolve and saturates at 0xFFFF_FFFF.

## Timing
- Lookup has zero latency: pred_taken and pred_target are valid in the same cycle as if_pc.
- BTB update is written at the clock edge. Same-cycle lookup of the updated index returns the pre-update contents (read-before-write).
- sel and redirect_pc are combinational in the resolve cycle. flush asserts on the following two unstalled cycles.
- Back-to-back mispredicts restart FL1; each one is counted.
- Reset:
  - All valid=0 and all ctr=01.
  - FSM=IDLE, flush=0, mispredict_cnt=0.
  - With valid=0, pred_taken=0 and pred_target=if_pc+4.
  - Reset mid-flush returns to IDLE on the next edge.
- ex_is_br and ex_is_jal both high is illegal; JAL handling wins.

## Structure
- Shared package bp_pkg holds:
  - sel encodings SEL_SEQ=0, SEL_JAL=1, SEL_REDIR=2
  - FSM state enum
  - ctr reset/allocate constants (CTR_WNT=01, CTR_WT=10, CTR_ST=11)
- Sub-module btb_array: storage plus async read port and sync write port, parameterised by ENTRIES.
- Counter update, mispredict detection and the FSM live in the top module.

## Test plan
- Reset, if_pc=0x100 → pred_taken=0, pred_target=0x104, flush=0, mispredict_cnt=0.
- Branch at 0x200 resolves taken to 0x180 with ex_pred_taken=0 →
  - sel=2, redirect_pc=0x180.
  - flush high for 2 cycles.
  - Next lookup of 0x200: pred_taken=1, target 0x180.
- Same branch resolves not taken three times → ctr 10→01→00→00.
  - First not-taken resolve is a mispredict (predicted taken).
  - Later resolves predict not taken; cnt increments only on actual mispredicts.
- JAL at 0x300 to 0x400, first encounter → mispredict, redirect_pc=0x400, entry ctr=11; second encounter → no mispredict, sel=0.
- Aliasing: 0x200 is allocated, then 0x200+4*ENTRIES is resolved taken → the entry is overwritten, and a 0x200 lookup now misses.
- Mispredict in FL1 with stall asserted for 3 cycles → flush stays high throughout, and the FSM restarts at FL1 after stall deasserts.
